// File: rtl/free_list_pkg.sv
// free_list_pkg: sizes and tag/pointer types for the physical-register free list
package free_list_pkg;
    localparam int NUM_PR = 64;
    localparam int NUM_LR = 32;
    localparam int FL_SIZE = NUM_PR - NUM_LR;
    localparam int TAG_W = $clog2(NUM_PR);
    localparam int IDX_W = $clog2(FL_SIZE);
    localparam int PTR_W = IDX_W + 1;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/free_list_if.sv
// free_list_if: rename-side bundle between the map table (master) and the free list (slave)
interface free_list_if;
    logic                 en;
    logic                 dispatch_en;
    logic                 retire_en;
    free_list_pkg::tag_t  T_old_in;
    logic                 rollback_en;
    free_list_pkg::tag_t  T_out;
    logic                 free_valid;
    free_list_pkg::ptr_t  free_count;
    modport master (
        output en, dispatch_en, retire_en, T_old_in, rollback_en,
        input  T_out, free_valid, free_count
    );
    modport slave (
        input  en, dispatch_en, retire_en, T_old_in, rollback_en,
        output T_out, free_valid, free_count
    );
endinterface

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical tags with single-cycle rollback to the committed head
module free_list
    import free_list_pkg::*;
(
    input logic        clock,
    input logic        reset,
    free_list_if.slave fl
);
    tag_t entry_q [FL_SIZE];
    tag_t entry_d [FL_SIZE];
    ptr_t head_q, head_d, tail_q, tail_d, c_head_q, c_head_d;
    ptr_t count;
    logic push, pop;
    always_comb begin
        count = tail_q - head_q;
        push = fl.en && fl.retire_en;
        pop = fl.en && fl.dispatch_en && !fl.rollback_en && count != '0;
        entry_d = entry_q;
        if (push) entry_d[tail_q[IDX_W-1:0]] = fl.T_old_in;
        tail_d = push ? tail_q + ptr_t'(1) : tail_q;
        c_head_d = push ? c_head_q + ptr_t'(1) : c_head_q;
        // a rollback discards every speculative pop, including one requested this cycle
        head_d = (fl.en && fl.rollback_en) ? c_head_q + ptr_t'(fl.retire_en) : head_q + ptr_t'(pop);
    end
    assign fl.T_out = entry_q[head_q[IDX_W-1:0]];
    assign fl.free_valid = count != '0;
    assign fl.free_count = count;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++) entry_q[i] <= tag_t'(NUM_LR + i);
            head_q <= '0;
            c_head_q <= '0;
            tail_q <= ptr_t'(FL_SIZE);
        end else begin
            entry_q <= entry_d;
            head_q <= head_d;
            tail_q <= tail_d;
            c_head_q <= c_head_d;
        end
    end
    // a full list can only accept a freed tag if a tag leaves in the same cycle
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && count == ptr_t'(FL_SIZE)));
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed stimulus with an unbounded-index model of the free tag sequence
module tb_free_list;
    logic clock = 0;
    logic reset = 1;
    int checks = 0;
    int errors = 0;
    int m_head, m_tail, m_chead;
    logic [5:0] hist [0:1023];

    free_list_if fl();
    free_list u_dut (.clock(clock), .reset(reset), .fl(fl.slave));

    always #5 clock = ~clock;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1 reset = 0;
    endtask

    task automatic drive(input logic d, input logic r, input logic rb, input logic [5:0] t);
        fl.dispatch_en = d;
        fl.retire_en = r;
        fl.rollback_en = rb;
        fl.T_old_in = t;
    endtask

    // tags are laid out at ever-increasing absolute positions; no wrap in the model
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) hist[i] <= 6'(32 + i);
            m_head <= 0;
            m_chead <= 0;
            m_tail <= 32;
        end else if (fl.en) begin
            if (fl.retire_en) begin
                hist[m_tail[9:0]] <= fl.T_old_in;
                m_tail <= m_tail + 1;
                m_chead <= m_chead + 1;
            end
            if (fl.rollback_en) m_head <= m_chead + (fl.retire_en ? 1 : 0);
            else if (fl.dispatch_en && m_tail != m_head) m_head <= m_head + 1;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("model_count", int'(fl.free_count), m_tail - m_head);
            chk("model_valid", int'(fl.free_valid), (m_tail != m_head) ? 1 : 0);
            if (m_tail != m_head) chk("model_T_out", int'(fl.T_out), int'(hist[m_head[9:0]]));
        end
    end

    initial begin
        fl.en = 0;
        drive(0, 0, 0, 0);
        #12 reset = 0;
        chk("reset_T_out", int'(fl.T_out), 32);
        chk("reset_valid", int'(fl.free_valid), 1);
        chk("reset_count", int'(fl.free_count), 32);
        fl.en = 1;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("pop_seq_T_out", int'(fl.T_out), 32 + i);
            cyc();
        end
        chk("pop3_T_out", int'(fl.T_out), 35);
        chk("pop3_count", int'(fl.free_count), 29);
        drive(0, 0, 0, 0);
        #2 reset = 1;
        #1;
        chk("async_T_out", int'(fl.T_out), 32);
        chk("async_valid", int'(fl.free_valid), 1);
        chk("async_count", int'(fl.free_count), 32);
        reset = 0;
        drive(1, 0, 0, 0);
        repeat (32) cyc();
        chk("empty_valid", int'(fl.free_valid), 0);
        chk("empty_count", int'(fl.free_count), 0);
        repeat (2) cyc();
        chk("empty_hold_count", int'(fl.free_count), 0);
        chk("empty_hold_T_out", int'(fl.T_out), 32);
        drive(0, 1, 0, 5);
        cyc();
        drive(0, 0, 0, 0);
        chk("refill_valid", int'(fl.free_valid), 1);
        chk("refill_T_out", int'(fl.T_out), 5);
        chk("refill_count", int'(fl.free_count), 1);
        do_reset();
        drive(1, 1, 0, 7);
        cyc();
        drive(1, 0, 0, 0);
        chk("pushpop_count", int'(fl.free_count), 32);
        chk("pushpop_T_out", int'(fl.T_out), 33);
        repeat (31) cyc();
        chk("pushpop_entry0", int'(fl.T_out), 7);
        chk("pushpop_tail_count", int'(fl.free_count), 1);
        drive(0, 0, 0, 0);
        do_reset();
        drive(1, 0, 0, 0);
        repeat (4) cyc();
        drive(0, 1, 0, 1);
        cyc();
        drive(0, 1, 1, 2);
        cyc();
        drive(0, 0, 0, 0);
        chk("rollback_T_out", int'(fl.T_out), 34);
        chk("rollback_count", int'(fl.free_count), 32);
        chk("rollback_valid", int'(fl.free_valid), 1);
        fl.en = 0;
        drive(1, 1, 1, 9);
        cyc();
        fl.en = 1;
        drive(0, 0, 0, 0);
        chk("hold_T_out", int'(fl.T_out), 34);
        chk("hold_count", int'(fl.free_count), 32);
        drive(1, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0);
        chk("after_hold_T_out", int'(fl.T_out), 35);
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(1, 0, 0, 0);
            cyc();
            drive(0, 1, 0, 6'((i * 7 + 3) % 64));
            cyc();
        end
        drive(0, 0, 0, 0);
        chk("wrap_T_out", int'(fl.T_out), 59);
        chk("wrap_count", int'(fl.free_count), 32);
        drive(1, 0, 0, 0);
        cyc();
        chk("wrap_next_T_out", int'(fl.T_out), 2);
        repeat (31) cyc();
        drive(0, 0, 0, 0);
        chk("drain_valid", int'(fl.free_valid), 0);
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
